// File: rtl/modulation_pkg.sv
// Types and constants shared by the packet framer and the QPSK modulator bench.
package modulation_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_PAYLOAD,
    S_CHK,
    S_GAP,
    S_FLUSH
  } framer_state_e;

  localparam logic [7:0] PREAMBLE_DEFAULT = 8'hE4;
  localparam int unsigned MIN_GAP = 3;

endpackage

// File: rtl/framer_byte_buf.sv
// One-entry payload holding register. Zero-latency ready; refuses bytes once full or once the packet's last byte is in.
// Discards everything while flushing.
module framer_byte_buf (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic [7:0] din_i,
  input  logic       din_valid_i,
  input  logic       din_last_i,
  output logic       din_ready_o,
  input  logic       flush_i,
  input  logic       pop_i,
  input  logic       clr_last_i,
  output logic       full_o,
  output logic [7:0] byte_o,
  output logic       last_o,
  output logic       last_taken_o
);

  logic       full_q, full_d;
  logic       last_q, last_d;
  logic       taken_q, taken_d;
  logic [7:0] byte_q, byte_d;
  logic       accept;

  assign din_ready_o  = flush_i | (~full_q & ~taken_q);
  assign accept       = din_valid_i & din_ready_o;
  assign full_o       = full_q;
  assign byte_o       = byte_q;
  assign last_o       = last_q;
  assign last_taken_o = taken_q;

  always_comb begin
    full_d  = full_q;
    byte_d  = byte_q;
    last_d  = last_q;
    taken_d = taken_q;
    if (pop_i || flush_i) full_d = 1'b0;
    if (accept && !flush_i) begin
      full_d = 1'b1;
      byte_d = din_i;
      last_d = din_last_i;
    end
    if (accept && din_last_i) taken_d = 1'b1;
    // Clearing on GAP entry wins over a last byte accepted in that same cycle.
    if (clr_last_i) taken_d = 1'b0;
  end

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      full_q  <= 1'b0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      taken_q <= taken_d;
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Frames payload bytes as preamble + payload + optional XOR checksum, serialised MSB-first; first bit two cycles after
// the first byte is accepted. Backpressure via din_ready from the one-entry buffer; an empty buffer mid-packet aborts.
module packet_framer
  import modulation_pkg::*;
#(
  parameter int unsigned                PREAMBLE_LEN = 8,
  parameter logic [PREAMBLE_LEN-1:0]    PREAMBLE     = PREAMBLE_LEN'(PREAMBLE_DEFAULT),
  parameter bit                         CHK_EN       = 1'b1,
  parameter int unsigned                GAP_CYCLES   = MIN_GAP
) (
  input  logic       clk_slow,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       valid,
  output logic       bit_out,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_underrun
);

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  framer_state_e           state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              bidx_q, bidx_d;
  logic [7:0]              sh_q, sh_d;
  logic [PREAMBLE_LEN-1:0] pre_q, pre_d;
  logic                    cur_last_q, cur_last_d;
  logic [7:0]              chk_q, chk_d;
  logic                    valid_q, valid_d;
  logic                    bit_q, bit_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic       nxt_full, nxt_last, last_taken, pop, clr_last;
  logic [7:0] nxt_byte;

  framer_byte_buf u_buf (
    .clk_slow     (clk_slow),
    .rst          (rst),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_last_i   (din_last),
    .din_ready_o  (din_ready),
    .flush_i      (state_q == S_FLUSH),
    .pop_i        (pop),
    .clr_last_i   (clr_last),
    .full_o       (nxt_full),
    .byte_o       (nxt_byte),
    .last_o       (nxt_last),
    .last_taken_o (last_taken)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bidx_d     = bidx_q;
    sh_d       = sh_q;
    pre_d      = pre_q;
    cur_last_d = cur_last_q;
    chk_d      = chk_q;
    pop        = 1'b0;
    clr_last   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nxt_full) begin
          state_d = S_PREAMBLE;
          cnt_d   = 8'd0;
          pre_d   = PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        pre_d = pre_q << 1;
        if (cnt_q == PRE_LAST) begin
          state_d    = S_PAYLOAD;
          sh_d       = nxt_byte;
          cur_last_d = nxt_last;
          chk_d      = nxt_byte;
          bidx_d     = 3'd0;
          pop        = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_PAYLOAD: begin
        if (bidx_q != 3'd7) begin
          sh_d   = sh_q << 1;
          bidx_d = bidx_q + 3'd1;
        end else if (cur_last_q) begin
          if (CHK_EN) begin
            state_d = S_CHK;
            sh_d    = chk_q;
            bidx_d  = 3'd0;
          end else begin
            state_d = S_GAP;
            cnt_d   = 8'd0;
          end
        end else if (nxt_full) begin
          sh_d       = nxt_byte;
          cur_last_d = nxt_last;
          chk_d      = chk_q ^ nxt_byte;
          bidx_d     = 3'd0;
          pop        = 1'b1;
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_CHK: begin
        if (bidx_q != 3'd7) begin
          sh_d   = sh_q << 1;
          bidx_d = bidx_q + 3'd1;
        end else begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      S_FLUSH: begin
        // din_ready is forced high here, so din_valid & din_last is an accepted last byte.
        if (last_taken || (din_valid && din_last)) begin
          state_d = S_GAP;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_GAP && state_q != S_GAP) clr_last = 1'b1;
  end

  // Outputs are registered from next-state values so they line up with the state being entered.
  always_comb begin
    valid_d = (state_d == S_PREAMBLE) || (state_d == S_PAYLOAD) || (state_d == S_CHK);
    bit_d   = 1'b0;
    if (state_d == S_PREAMBLE) bit_d = pre_d[PREAMBLE_LEN-1];
    else if (valid_d)          bit_d = sh_d[7];
    done_d  = ((state_d == S_CHK) && (bidx_d == 3'd7)) ||
              ((CHK_EN == 1'b0) && (state_d == S_PAYLOAD) && (bidx_d == 3'd7) && cur_last_d);
    err_d   = (state_d == S_FLUSH) && (state_q == S_PAYLOAD);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      bidx_q     <= 3'd0;
      sh_q       <= 8'h00;
      pre_q      <= '0;
      cur_last_q <= 1'b0;
      chk_q      <= 8'h00;
      valid_q    <= 1'b0;
      bit_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bidx_q     <= bidx_d;
      sh_q       <= sh_d;
      pre_q      <= pre_d;
      cur_last_q <= cur_last_d;
      chk_q      <= chk_d;
      valid_q    <= valid_d;
      bit_q      <= bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign valid        = valid_q;
  assign bit_out      = bit_q;
  assign busy         = busy_q;
  assign pkt_done     = done_q;
  assign err_underrun = err_q;

endmodule
